// File: rtl/packet_recv.sv
// packet_recv -- receive-side framer for the 32-bit GT lane packet protocol.
//
// The block hunts for the K-coded header word and then parses the packet that
// follows: a sequence word, a control word {len, 8'h00, type}, len payload
// words and a 32-bit additive checksum word. Payload words are streamed out
// one cycle after they are sampled. When the checksum word arrives the block
// reports whether the checksum matched and whether the sequence number broke
// continuity.
//
// Ports:
//   rx_clk, rst_n             GT RX user clock; async active-low reset
//   gt_rx_data/gt_rx_ctrl     aligned RX word and per-byte K flags
//   rx_data/_valid/_sof/_eof  payload stream, one word per cycle, no backpressure
//   rx_packet_type/_len       fields of the current packet
//   rx_seq_num                sequence number of the current packet
//   rx_packet_done            pulse when the checksum word has been consumed
//   rx_check_ok/rx_seq_err    qualified by rx_packet_done
//   rx_frame_err              pulse when a packet is aborted
//   rx_good_cnt/rx_bad_cnt    saturating packet counters
module packet_recv #(
  parameter logic [15:0] MAX_LEN = 16'd1024
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [31:0] gt_rx_data,
  input  logic [3:0]  gt_rx_ctrl,
  output logic [31:0] rx_data,
  output logic        rx_data_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [7:0]  rx_packet_type,
  output logic [15:0] rx_packet_len,
  output logic [31:0] rx_seq_num,
  output logic        rx_packet_done,
  output logic        rx_check_ok,
  output logic        rx_seq_err,
  output logic        rx_frame_err,
  output logic [15:0] rx_good_cnt,
  output logic [15:0] rx_bad_cnt
);

  typedef enum logic [2:0] {HUNT, SEQ, CTRL, DATA, CHECK} state_e;

  localparam logic [31:0] HDR_DATA = 32'hff0000bc;
  localparam logic [3:0]  HDR_CTRL = 4'b0001;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] len_q, len_d;
  logic [31:0] seq_q, seq_d;
  logic        done_q, done_d, ok_q, ok_d, serr_q, serr_d, ferr_q, ferr_d;
  logic [15:0] good_q, good_d, bad_q, bad_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] exp_q, exp_d;
  logic        lock_q, lock_d;

  logic        is_hdr, abort, len_bad, last_word;
  logic [15:0] len_w;

  assign is_hdr    = (gt_rx_ctrl == HDR_CTRL) && (gt_rx_data == HDR_DATA);
  // Any K flag inside a packet kills it, including a fresh header.
  assign abort     = (state_q != HUNT) && (gt_rx_ctrl != 4'b0000);
  assign len_w     = gt_rx_data[31:16];
  assign len_bad   = (len_w == 16'd0) || (len_w > MAX_LEN);
  // len_q >= 1 whenever DATA is entered, so len_q - 1 cannot underflow here.
  assign last_word = (cnt_q == len_q - 16'd1);

  // State register
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = is_hdr ? SEQ : HUNT;
    end else begin
      unique case (state_q)
        HUNT:    if (is_hdr) state_d = SEQ;
        SEQ:     state_d = CTRL;
        CTRL:    state_d = len_bad ? HUNT : DATA;
        DATA:    if (last_word) state_d = CHECK;
        CHECK:   state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Output / datapath next values; every output is registered.
  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    sof_d  = 1'b0;
    eof_d  = 1'b0;
    type_d = type_q;
    len_d  = len_q;
    seq_d  = seq_q;
    done_d = 1'b0;
    ok_d   = 1'b0;
    serr_d = 1'b0;
    ferr_d = 1'b0;
    good_d = good_q;
    bad_d  = bad_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    exp_d  = exp_q;
    lock_d = lock_q;
    if (abort) begin
      ferr_d = 1'b1;
      bad_d  = (bad_q == 16'hffff) ? bad_q : bad_q + 16'd1;
    end else begin
      unique case (state_q)
        SEQ: seq_d = gt_rx_data;
        CTRL: begin
          type_d = gt_rx_data[7:0];
          len_d  = len_w;
          if (len_bad) begin
            ferr_d = 1'b1;
            bad_d  = (bad_q == 16'hffff) ? bad_q : bad_q + 16'd1;
          end else begin
            cnt_d = 16'd0;
            sum_d = 32'd0;
          end
        end
        DATA: begin
          data_d = gt_rx_data;
          vld_d  = 1'b1;
          sof_d  = (cnt_q == 16'd0);
          eof_d  = last_word;
          sum_d  = sum_q + gt_rx_data;
          cnt_d  = cnt_q + 16'd1;
        end
        CHECK: begin
          done_d = 1'b1;
          ok_d   = (gt_rx_data == sum_q);
          // First completed packet after reset only establishes the lock.
          serr_d = lock_q && (seq_q != exp_q);
          exp_d  = seq_q + 32'd1;
          lock_d = 1'b1;
          if (gt_rx_data == sum_q) good_d = (good_q == 16'hffff) ? good_q : good_q + 16'd1;
          else                     bad_d  = (bad_q  == 16'hffff) ? bad_q  : bad_q  + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      type_q <= '0;
      len_q  <= '0;
      seq_q  <= '0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      serr_q <= 1'b0;
      ferr_q <= 1'b0;
      good_q <= '0;
      bad_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      exp_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      sof_q  <= sof_d;
      eof_q  <= eof_d;
      type_q <= type_d;
      len_q  <= len_d;
      seq_q  <= seq_d;
      done_q <= done_d;
      ok_q   <= ok_d;
      serr_q <= serr_d;
      ferr_q <= ferr_d;
      good_q <= good_d;
      bad_q  <= bad_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      exp_q  <= exp_d;
      lock_q <= lock_d;
    end
  end

  assign rx_data        = data_q;
  assign rx_data_valid  = vld_q;
  assign rx_sof         = sof_q;
  assign rx_eof         = eof_q;
  assign rx_packet_type = type_q;
  assign rx_packet_len  = len_q;
  assign rx_seq_num     = seq_q;
  assign rx_packet_done = done_q;
  assign rx_check_ok    = ok_q;
  assign rx_seq_err     = serr_q;
  assign rx_frame_err   = ferr_q;
  assign rx_good_cnt    = good_q;
  assign rx_bad_cnt     = bad_q;

endmodule

// File: tb/tb_packet_recv.sv
// Randomized bench for packet_recv: packets are described at the packet level
// (seq, type, payload, checksum error, abort point) and a scoreboard of
// expected beats, done reports and frame errors is filled as words are sent.
module tb_packet_recv;

  localparam logic [31:0] HDR  = 32'hff0000bc;
  localparam logic [31:0] CORR = 32'hf7f7f7f7;
  localparam logic [31:0] DUMY = 32'hff000055;

  logic        rx_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [31:0] gt_rx_data = DUMY;
  logic [3:0]  gt_rx_ctrl = 4'h0;
  logic [31:0] rx_data;
  logic        rx_data_valid, rx_sof, rx_eof;
  logic [7:0]  rx_packet_type;
  logic [15:0] rx_packet_len;
  logic [31:0] rx_seq_num;
  logic        rx_packet_done, rx_check_ok, rx_seq_err, rx_frame_err;
  logic [15:0] rx_good_cnt, rx_bad_cnt;

  packet_recv dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .gt_rx_data(gt_rx_data), .gt_rx_ctrl(gt_rx_ctrl),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_packet_type(rx_packet_type), .rx_packet_len(rx_packet_len), .rx_seq_num(rx_seq_num),
    .rx_packet_done(rx_packet_done), .rx_check_ok(rx_check_ok), .rx_seq_err(rx_seq_err),
    .rx_frame_err(rx_frame_err), .rx_good_cnt(rx_good_cnt), .rx_bad_cnt(rx_bad_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        ok;
    logic        serr;
    logic [7:0]  typ;
    logic [15:0] len;
    logic [31:0] seq;
  } done_t;

  // Scoreboard and reference state
  logic [33:0] beat_q[$];
  done_t       done_q[$];
  int          ferr_pend = 0;
  bit          lock_m = 0;
  logic [31:0] exp_m = '0;
  logic [15:0] good_m = '0, bad_m = '0;
  logic [31:0] pl[$];
  bit          prev_eof = 0;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  task automatic drive(input logic [3:0] c, input logic [31:0] d);
    @(negedge rx_clk);
    gt_rx_ctrl = c;
    gt_rx_data = d;
  endtask

  // Idle words between packets: dummy, correction or arbitrary ctrl-0 words.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0: drive(4'h0, DUMY);
        1: drive(4'hf, CORR);
        default: drive(4'h0, $urandom);
      endcase
    end
    if (n > 0) begin
      chk("good_cnt", rx_good_cnt, good_m);
      chk("bad_cnt", rx_bad_cnt, bad_m);
    end
  endtask

  // abort_at in [0,len] replaces that payload/checksum word with a K word.
  task automatic send_pkt(input logic [31:0] seq, input logic [7:0] typ, input int len,
                          input logic [31:0] cdelta, input bit hdr, input int abort_at,
                          input bit abort_hdr);
    logic [31:0] sum;
    done_t d;
    if (hdr) drive(4'h1, HDR);
    drive(4'h0, seq);
    drive(4'h0, {len[15:0], 8'h00, typ});
    if (len == 0 || len > 1024) begin
      ferr_pend++;
      bad_m = sat(bad_m);
      return;
    end
    sum = '0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        if (abort_hdr) drive(4'h1, HDR);
        else           drive(4'hf, CORR);
        ferr_pend++;
        bad_m = sat(bad_m);
        return;
      end
      if (i < len) begin
        drive(4'h0, pl[i]);
        sum = sum + pl[i];
        beat_q.push_back({i == 0, i == len - 1, pl[i]});
      end
    end
    drive(4'h0, sum + cdelta);
    d.ok   = (cdelta == 0);
    d.serr = lock_m && (seq != exp_m);
    d.typ  = typ;
    d.len  = len[15:0];
    d.seq  = seq;
    done_q.push_back(d);
    lock_m = 1;
    exp_m  = seq + 32'd1;
    if (d.ok) good_m = sat(good_m);
    else      bad_m  = sat(bad_m);
  endtask

  // Output monitor
  always @(negedge rx_clk) begin
    if (rst_n) begin
      if (rx_data_valid) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
        else chk("beat", {rx_sof, rx_eof, rx_data}, beat_q.pop_front());
      end
      if (rx_packet_done) begin
        chk("done_after_eof", prev_eof, 1);
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          done_t e;
          e = done_q.pop_front();
          chk("check_ok", rx_check_ok, e.ok);
          chk("seq_err", rx_seq_err, e.serr);
          chk("pkt_type", rx_packet_type, e.typ);
          chk("pkt_len", rx_packet_len, e.len);
          chk("seq_num", rx_seq_num, e.seq);
        end
      end
      if (rx_frame_err) begin
        chk("frame_err_expected", ferr_pend > 0, 1);
        if (ferr_pend > 0) ferr_pend--;
      end
      prev_eof = rx_data_valid && rx_eof;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk(tag, {rx_data, rx_data_valid, rx_sof, rx_eof, rx_packet_type, rx_packet_len,
              rx_seq_num, rx_packet_done, rx_check_ok, rx_seq_err, rx_frame_err,
              rx_good_cnt, rx_bad_cnt} == '0, 1);
  endtask

  initial begin
    int len;
    bit skip_hdr;
    logic [31:0] s;
    // Reset state
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Nominal packet with leading correction and dummy words
    drive(4'hf, CORR);
    drive(4'h0, DUMY);
    pl = '{32'd1, 32'd2, 32'd3};
    send_pkt(32'd0, 8'h5a, 3, 32'd0, 1, -1, 0);
    idle(2);
    chk("nominal_good_cnt", rx_good_cnt, 16'd1);
    chk("nominal_type", rx_packet_type, 8'h5a);
    chk("nominal_len", rx_packet_len, 16'd3);

    // Checksum 7 instead of 6
    send_pkt(32'd1, 8'h5a, 3, 32'd1, 1, -1, 0);
    idle(2);
    chk("csum_err_bad_cnt", rx_bad_cnt, 16'd1);
    chk("csum_err_good_cnt", rx_good_cnt, 16'd1);

    // Single word, then modular wrap of the sum
    pl = '{32'hffffffff};
    send_pkt(32'd2, 8'h01, 1, 32'd0, 1, -1, 0);
    pl = '{32'hffffffff, 32'd2};
    send_pkt(32'd3, 8'h02, 2, 32'd0, 1, -1, 0);
    idle(2);
    chk("wrap_good_cnt", rx_good_cnt, 16'd3);

    // Reset during DATA
    pl = '{32'h11, 32'h22, 32'h33, 32'h44};
    drive(4'h1, HDR);
    drive(4'h0, 32'd77);
    drive(4'h0, {16'd4, 8'h00, 8'h33});
    drive(4'h0, pl[0]);
    beat_q.push_back({1'b1, 1'b0, pl[0]});
    drive(4'h0, pl[1]);
    beat_q.push_back({1'b0, 1'b0, pl[1]});
    @(negedge rx_clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midreset_outputs");
    repeat (2) @(negedge rx_clk);
    chk_all_zero("midreset_hold");
    lock_m = 0; good_m = '0; bad_m = '0;
    rst_n = 1'b1;
    idle(1);

    // Sequence continuity: 5 (first after reset), 6, 8 (gap), 9
    pl = '{32'h5, 32'h6};
    send_pkt(32'd5, 8'h10, 2, 32'd0, 1, -1, 0);
    idle(2);
    chk("post_reset_good_cnt", rx_good_cnt, 16'd1);
    send_pkt(32'd6, 8'h10, 2, 32'd0, 1, -1, 0);
    send_pkt(32'd8, 8'h10, 2, 32'd0, 1, -1, 0);
    send_pkt(32'd9, 8'h10, 2, 32'd0, 1, -1, 0);
    idle(2);

    // Header after data word 2 of a len=4 packet, then immediate resync
    pl = '{32'ha, 32'hb, 32'hc, 32'hd};
    send_pkt(32'd10, 8'h20, 4, 32'd0, 1, 2, 1);
    pl = '{32'h100, 32'h200};
    send_pkt(32'd10, 8'h21, 2, 32'd0, 0, -1, 0);
    idle(2);

    // Illegal lengths
    send_pkt(32'd11, 8'h30, 0, 32'd0, 1, -1, 0);
    idle(1);
    send_pkt(32'd11, 8'h31, 1025, 32'd0, 1, -1, 0);
    idle(2);
    chk("len_err_type_latched", rx_packet_type, 8'h31);

    // Randomized traffic
    skip_hdr = 0;
    for (int p = 0; p < 200; p++) begin
      int ab;
      bit abh;
      if ($urandom_range(0, 15) == 0) len = $urandom_range(0, 1) ? 0 : 1025;
      else len = $urandom_range(1, 8);
      pl.delete();
      for (int i = 0; i < len && len <= 1024; i++) pl.push_back($urandom);
      s   = ($urandom_range(0, 3) == 0) ? $urandom : exp_m;
      ab  = (len >= 1 && len <= 1024 && $urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      abh = $urandom_range(0, 1);
      send_pkt(s, 8'($urandom), len, ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 99)) : 32'd0,
               !skip_hdr, ab, abh);
      // After a header abort the receiver already sits past the header.
      skip_hdr = (ab >= 0) && abh;
      if (!skip_hdr) idle($urandom_range(0, 3));
    end
    if (skip_hdr) begin
      pl = '{32'h1};
      send_pkt(exp_m, 8'h0, 1, 32'd0, 0, -1, 0);
    end
    idle(3);
    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    chk("frame_errs_left", ferr_pend, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/packet_recv.md
# packet_recv

Receive-side framer for the 32-bit GT lane packet protocol. It consumes the word-aligned RX data/control stream from the transceiver, finds the packet header and extracts sequence number, length and type. It streams out the payload words, then verifies the 32-bit additive checksum and the sequence continuity. It sits between the GT RX user interface and the receive-side packet consumer, mirroring the transmit framer on the far end of the link.

## Interface
- MAX_LEN, 16'd1024: largest accepted payload length in words. Lengths 0 or > MAX_LEN are framing errors.
- rx_clk  in  1  GT RX user clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- gt_rx_data  in  32  aligned RX word. Byte 0 is [7:0].
- gt_rx_ctrl  in  4  per-byte K flags; bit0 belongs to [7:0].
- rx_data  out  32  payload word.
- rx_data_valid  out  1  rx_data carries a payload word this cycle.
- rx_sof  out  1  first payload word of the packet, coincident with rx_data_valid.
- rx_eof  out  1  last payload word of the packet, coincident with rx_data_valid.
- rx_packet_type  out  8  type field of the current packet.
- rx_packet_len  out  16  length field of the current packet.
- rx_seq_num  out  32  sequence number of the current packet.
- rx_packet_done  out  1  one-cycle pulse when the checksum word has been received.
- rx_check_ok  out  1  valid with rx_packet_done: checksum matched.
- rx_seq_err  out  1  valid with rx_packet_done: sequence discontinuity.
- rx_frame_err  out  1  one-cycle pulse when a packet is aborted.
- rx_good_cnt  out  16  count of packets with matching checksum; saturating.
- rx_bad_cnt  out  16  count of checksum failures plus aborts; saturating.

## Operation
- Header word: data 32'hff0000bc with ctrl 4'b0001. Preceding correction words (f7f7f7f7/1111) and dummy words (ff000055/0000) are ignored. Any other word outside a packet is ignored.
- Packet layout after the header: seq word; ctrl word {len[15:0], 8'h00, type[7:0]}; exactly len payload words; checksum word. All of these words carry ctrl 0000.
- State machine:
  - HUNT → SEQ on a header word.
  - SEQ: latch rx_seq_num; → CTRL.
  - CTRL: latch type and len.
    - If len == 0 or len > MAX_LEN: pulse rx_frame_err, → HUNT.
    - Otherwise: clear the word counter and the running sum; → DATA.
  - DATA: emit each payload word and add it to the sum (mod 2^32). After word number len → CHECK.
  - CHECK: compare the input word with the sum. Pulse rx_packet_done, drive rx_check_ok and rx_seq_err, update the counters; → HUNT.
- Abort, in SEQ, CTRL, DATA or CHECK: any word with gt_rx_ctrl != 0 aborts the packet.
  - Pulse rx_frame_err, increment rx_bad_cnt.
  - If the aborting word is itself a header: → SEQ (immediate resync). Otherwise → HUNT.
  - rx_eof is not asserted for an aborted packet.
- Sequence check:
  - The first completed packet after reset sets the expected value to seq+1 and reports no error.
  - For later packets, rx_seq_err = (seq != expected). The expected value then becomes seq+1 in either case (resync). It wraps 32'hffffffff → 0.
  - Aborted packets do not update the expected value.
- rx_good_cnt and rx_bad_cnt saturate at 16'hffff.
- Reset values (also applied mid-packet on rst_n low):
  - State: HUNT.
  - All outputs 0; counters 0.
  - Sequence lock cleared.
  - A packet in progress is discarded silently: no done and no frame_err pulse.

## Timing
- All outputs are registered. A word sampled at edge N produces its output at edge N, visible during cycle N+1. Latency is one cycle.
- rx_data_valid follows the input payload cadence exactly, with no backpressure. The consumer must accept one word per cycle.
- len == 1: rx_sof and rx_eof are asserted on the same beat.
- rx_packet_done occurs one cycle after the last rx_data_valid. Back-to-back packets with no idle words between them are supported.
- rx_packet_type, rx_packet_len and rx_seq_num are stable from the cycle after the CTRL word until the next packet's SEQ/CTRL words.

## Test plan
- Nominal packet: correction, dummy, header, seq=0, ctrl=0x0003005A, data 1,2,3, checksum 6.
  - Expect 3 valid beats, sof on 1 and eof on 3, type=0x5A, len=3.
  - Expect done with check_ok=1, seq_err=0, good_cnt=1.
- Checksum error: same packet with checksum 7.
  - Expect done with check_ok=0, bad_cnt=1, good_cnt unchanged.
- Single-word and wrap cases:
  - len=1, data 0xFFFFFFFF, checksum 0xFFFFFFFF: sof and eof on the same beat, check_ok=1.
  - len=2, data 0xFFFFFFFF and 2, checksum 1: check_ok=1 (mod-2^32 wrap).
- Sequence gap: packets with seq 5, 6, 8.
  - Expect seq_err = 0, 0, 1.
  - A following seq 9 gives seq_err=0.
- Abort cases:
  - A header arrives after data word 2 of a len=4 packet: frame_err pulse, no eof; the next packet decodes normally.
  - len=0 gives frame_err. len=MAX_LEN+1 gives frame_err.
- Reset mid-packet: assert rst_n low during DATA.
  - All outputs and counters read 0 with no done pulse.
  - A full packet afterwards gives good_cnt=1 and seq_err=0 (first packet after reset).
